// File: rtl/matmul_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply controller.
package matmul_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned NUM_OPERANDS = 8;
  localparam int unsigned NUM_RESULTS  = 4;
  localparam int unsigned NUM_STEPS    = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    OUTPUT
  } state_t;

  // Operand-buffer indices per MAC step: a0..a3 live at 0..3, b0..b3 at 4..7.
  localparam logic [2:0] SCHED_A [NUM_STEPS] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3};
  localparam logic [2:0] SCHED_B [NUM_STEPS] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd7};

endpackage

// File: rtl/mac_unit.sv
// Single shared multiplier with accumulator; i_first restarts the sum at this step.
module mac_unit
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_first,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic [2*DATA_W-1:0]   o_sum
);

  logic [2*DATA_W-1:0] r_acc;
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_base;

  assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
  assign w_base = i_first ? '0 : r_acc;
  // Exposed combinationally so the controller can latch a finished element on its last step.
  assign o_sum  = w_base + w_prod;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/matmul_controller.sv
// 2x2 matrix multiply: streams in A and B, runs 8 MAC steps, streams out C.
module matmul_controller
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*DATA_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  state_t              r_state;
  logic [DATA_W-1:0]   r_ops [NUM_OPERANDS];
  logic [2*DATA_W-1:0] r_res [NUM_RESULTS];
  logic [2:0]          r_in_cnt;
  logic [2:0]          r_step;
  logic [1:0]          r_ridx;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [2*DATA_W-1:0] r_out_data;
  logic                r_busy;
  logic                r_done;

  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_mac_en;
  logic [2*DATA_W-1:0] w_sum;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_mac_en   = (r_state == COMPUTE);

  mac_unit #(.DATA_W(DATA_W)) u_mac (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (w_mac_en),
    .i_first (~r_step[0]),
    .i_a     (r_ops[SCHED_A[r_step]]),
    .i_b     (r_ops[SCHED_B[r_step]]),
    .o_sum   (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_cnt    <= '0;
      r_step      <= '0;
      r_ridx      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int unsigned i = 0; i < NUM_OPERANDS; i++) r_ops[i] <= '0;
      for (int unsigned i = 0; i < NUM_RESULTS; i++)  r_res[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (clear) begin
        r_state     <= IDLE;
        r_in_cnt    <= '0;
        r_step      <= '0;
        r_ridx      <= '0;
        r_in_ready  <= 1'b1;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE, LOAD: begin
            r_in_ready <= 1'b1;
            if (w_in_xfer) begin
              r_ops[r_in_cnt] <= in_data;
              r_in_cnt        <= r_in_cnt + 3'd1;
              r_busy          <= 1'b1;
              if (r_in_cnt == 3'(NUM_OPERANDS - 1)) begin
                r_state    <= COMPUTE;
                r_in_ready <= 1'b0;
                r_step     <= '0;
              end else begin
                r_state <= LOAD;
              end
            end
          end
          COMPUTE: begin
            if (r_step[0]) r_res[r_step[2:1]] <= w_sum;
            r_step <= r_step + 3'd1;
            // c0 was latched at step 1, so it can be presented on the same edge c3 completes.
            if (r_step == 3'(NUM_STEPS - 1)) begin
              r_state     <= OUTPUT;
              r_out_valid <= 1'b1;
              r_out_data  <= r_res[0];
              r_ridx      <= '0;
            end
          end
          OUTPUT: begin
            if (w_out_xfer) begin
              if (r_ridx == 2'(NUM_RESULTS - 1)) begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_done      <= 1'b1;
                r_busy      <= 1'b0;
                r_in_ready  <= 1'b1;
                r_ridx      <= '0;
              end else begin
                r_ridx     <= r_ridx + 2'd1;
                r_out_data <= r_res[r_ridx + 2'd1];
              end
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_matmul_controller.sv
// Scoreboard bench for matmul_controller: stimulus pushes expected results, a negedge monitor pops them.
module tb_matmul_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] d;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          hold_pend = 1'b0;
  bit          done_exp  = 1'b0;
  bit          tog_en    = 1'b0;
  logic [15:0] held;

  matmul_controller #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Monitor: pops on every output transfer, checks hold-under-backpressure and done.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_pend = 1'b0;
      done_exp  = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(held));
      end
      hold_pend = 1'b0;
      if (done || done_exp) chk("done_pulse", 32'(done), 32'(done_exp));
      if (done) chk("done_in_ready", 32'(in_ready), 32'd1);
      done_exp = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          done_exp = e.last;
        end
      end else if (out_valid) begin
        hold_pend = 1'b1;
        held      = out_data;
      end
    end
  end

  task automatic push_exp(input logic [15:0] c0, input logic [15:0] c1,
                          input logic [15:0] c2, input logic [15:0] c3);
    exp_q.push_back('{c0, 1'b0});
    exp_q.push_back('{c1, 1'b0});
    exp_q.push_back('{c2, 1'b0});
    exp_q.push_back('{c3, 1'b1});
  endtask

  task automatic send(input logic [7:0] d, input bit keep);
    int unsigned n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("in_timeout", 32'(acc), 32'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic send_job(input logic [63:0] v, input bit gap, input bit keep, input bit lat);
    int unsigned n;
    for (int i = 0; i < 8; i++) begin
      send(v[63-8*i -: 8], (i == 7) ? keep : !gap);
      if (gap && i != 7) begin
        @(posedge clk);
        #1;
      end
    end
    if (lat) begin
      n = 0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (k == 1) begin
          chk("compute_in_ready", 32'(in_ready), 32'd0);
          chk("compute_busy", 32'(busy), 32'd1);
        end
        if (out_valid) begin
          n = k;
          break;
        end
      end
      chk("out_latency", n, 32'd8);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || out_valid) && n < 300);
    chk("idle_reached", 32'(busy || out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    #10 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Basic job
    push_exp(16'd19, 16'd22, 16'd43, 16'd50);
    send_job({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Wraparound
    push_exp(16'd64514, 16'd64514, 16'd64514, 16'd64514);
    send_job({8{8'd255}}, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Identity B with input gaps and toggling out_ready
    tog_en = 1'b1;
    fork
      begin
        while (tog_en) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join_none
    push_exp(16'd1, 16'd2, 16'd3, 16'd4);
    send_job({8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd0, 8'd0, 8'd1}, 1'b1, 1'b0, 1'b1);
    wait_idle();
    tog_en = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Clear on the 4th COMPUTE cycle
    send_job({8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7}, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("clr_no_out_valid", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    push_exp(16'd8, 16'd2, 16'd10, 16'd16);
    send_job({8'd2, 8'd0, 8'd1, 8'd3, 8'd4, 8'd1, 8'd2, 8'd5}, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Reset after five loaded elements
    for (int i = 0; i < 5; i++) send(8'(i + 10), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ready_again", 32'(in_ready), 32'd1);
    push_exp(16'd6, 16'd10, 16'd14, 16'd20);
    send_job({8'd3, 8'd1, 8'd2, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4}, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Back-to-back jobs with in_valid held high
    push_exp(16'd19, 16'd22, 16'd43, 16'd50);
    send_job({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0, 1'b1, 1'b0);
    push_exp(16'd33, 16'd50, 16'd25, 16'd38);
    send_job({8'd9, 8'd8, 8'd7, 8'd6, 8'd1, 8'd2, 8'd3, 8'd4}, 1'b0, 1'b0, 1'b0);
    wait_idle();

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/matmul_controller.md
MATMUL_CONTROLLER -- requirements
Module: matmul_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand element width; results are 2*DATA_W wide.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port clear  input  1  synchronous abort; discards the job and returns to IDLE.
REQ-005 SHALL have port in_data  input  DATA_W  operand byte stream.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  the block accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  2*DATA_W  result element.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the 4th result is accepted.

Function
REQ-013 SHALL implement the states IDLE, LOAD, COMPUTE and OUTPUT.
REQ-014 SHALL define an input transfer as in_valid && in_ready on a rising edge, and an output transfer as out_valid && out_ready on a rising edge.
REQ-015 SHALL assert in_ready only in IDLE and LOAD, and SHALL hold it low in COMPUTE and OUTPUT.
REQ-016 SHALL accept 8 elements in the fixed order a0, a1, a2, a3, b0, b1, b2, b3 (A and B row-major 2x2).
- The 1st transfer moves IDLE to LOAD.
- The 8th transfer moves LOAD to COMPUTE.
- Gaps in in_valid are allowed.
REQ-017 SHALL execute in COMPUTE exactly 8 steps, one multiply-accumulate per cycle, using one shared DATA_W x DATA_W multiplier, in this order:
- a0*b0, a1*b2 -> c0
- a0*b1, a1*b3 -> c1
- a2*b0, a3*b2 -> c2
- a2*b1, a3*b3 -> c3
REQ-018 SHALL clear the accumulator at the first step of each element; each result is the sum of two products truncated to 2*DATA_W bits (wraps modulo 2^(2*DATA_W)).
REQ-019 SHALL enter OUTPUT on the 8th rising edge after the edge that accepted b3, with out_valid high and out_data = c0 in that cycle.
REQ-020 SHALL present c0, c1, c2, c3 in order, holding out_data stable and out_valid high until each is transferred (backpressure tolerant).
REQ-021 SHALL, on the transfer of c3, pulse done for exactly one cycle, drop out_valid and return to IDLE.
REQ-022 SHALL be able to accept a new a0 in the cycle immediately after done.
REQ-023 SHALL keep out_valid low in every state except OUTPUT.
REQ-024 SHALL give clear priority over every simultaneous handshake:
- the state goes to IDLE and the element count resets;
- no transfer is counted in that cycle;
- done is not pulsed.
REQ-025 SHALL treat in_valid in COMPUTE and OUTPUT as a no-op; no data is consumed.

Reset
REQ-026 SHALL, while rst is high, force state=IDLE, all counters=0, accumulator and operand registers=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-027 SHALL raise in_ready in the first cycle after rst deasserts.
REQ-028 SHALL abandon any job on a reset asserted mid-operation, with no residual output afterwards.

Structure
REQ-029 SHALL take from package matmul_pkg:
- the state enumeration;
- DATA_W default;
- NUM_OPERANDS=8, NUM_RESULTS=4, NUM_STEPS=8;
- the step-to-operand-index schedule table.
REQ-030 SHALL instantiate one sub-module, mac_unit, which performs multiply plus accumulate with a clear-on-first-step input.
REQ-031 SHALL keep sequencing, counters and handshake logic in matmul_controller.

Verification
REQ-032 SHALL pass: A=[1,2,3,4], B=[5,6,7,8], out_ready=1 -> out 19, 22, 43, 50, with done pulsed once.
REQ-033 SHALL pass: all 8 elements = 255 -> all four results = 64514 (wrapped).
REQ-034 SHALL pass: A=[1,2,3,4], B=[1,0,0,1] with out_ready toggling every other cycle -> out 1, 2, 3, 4, each held stable until accepted.
REQ-035 SHALL pass: clear asserted on the 4th COMPUTE cycle -> IDLE next cycle, no out_valid, and a following job returns correct results.
REQ-036 SHALL pass: rst asserted after 5 loaded elements -> all outputs 0; a new 8-element job afterwards returns correct results.
REQ-037 SHALL pass: two back-to-back jobs with in_valid held high -> 2nd a0 accepted the cycle after done, and both result sets are correct.
